// File: rtl/alu_pipe_hs.sv
// Handshaked integer ALU: fixed-latency pipe (LAT = 2 + MUL_STAGES) with global stall,
// plus an optional restoring divider compiled in with `define ALU_DIV_EN.
//
// Divider FSM
//   state | meaning
//   IDLE  | no divide in flight; ops accepted whenever the pipe can advance
//   DRAIN | divide captured; waiting for all fixed-pipe stages and the output to empty
//   CALC  | one quotient bit per cycle, DATA_W cycles
//   DONE  | divider result sits in the output register until consumed
module alu_pipe_hs #(
   parameter int DATA_W     = 32,
   parameter int MUL_STAGES = 1,
   parameter int TAG_W      = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [TAG_W-1:0]  out_tag,
   output logic              out_err
);

   localparam int SH_W = $clog2(DATA_W);
   localparam int NP   = MUL_STAGES + 1;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_MUL  = 4'd2;
   localparam logic [3:0] OP_ABS  = 4'd3;
   localparam logic [3:0] OP_SLT  = 4'd4;
   localparam logic [3:0] OP_SLTU = 4'd5;
   localparam logic [3:0] OP_SEQ  = 4'd6;
   localparam logic [3:0] OP_MIN  = 4'd7;
   localparam logic [3:0] OP_SLL  = 4'd8;
   localparam logic [3:0] OP_SRL  = 4'd9;
   localparam logic [3:0] OP_SRA  = 4'd10;
   localparam logic [3:0] OP_AND  = 4'd11;
   localparam logic [3:0] OP_OR   = 4'd12;
   localparam logic [3:0] OP_XOR  = 4'd13;

   logic              adv;
   logic              acc;
   logic              is_div;
   logic              div_idle;
   logic              div_load;
   logic [DATA_W-1:0] div_res;
   logic [TAG_W-1:0]  div_tag;
   logic              div_err;

   logic              s0_valid;
   logic [3:0]        s0_op;
   logic [DATA_W-1:0] s0_a;
   logic [DATA_W-1:0] s0_b;
   logic [TAG_W-1:0]  s0_tag;

   logic              p_valid [NP];
   logic [DATA_W-1:0] p_res   [NP];
   logic              p_err   [NP];
   logic [TAG_W-1:0]  p_tag   [NP];

   logic [DATA_W-1:0] alu_res;
   logic              alu_err;
   logic [SH_W-1:0]   shamt;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv && div_idle;
   assign acc      = in_valid && in_ready;
   assign shamt    = s0_b[SH_W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_valid <= 1'b0;
         s0_op    <= '0;
         s0_a     <= '0;
         s0_b     <= '0;
         s0_tag   <= '0;
      end else if (adv) begin
         s0_valid <= acc && !is_div;
         s0_op    <= in_op;
         s0_a     <= in_a;
         s0_b     <= in_b;
         s0_tag   <= in_tag;
      end
   end

   // Everything is computed from stage 0; the remaining stages only pad latency.
   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (s0_op)
         OP_ADD:  alu_res = s0_a + s0_b;
         OP_SUB:  alu_res = s0_a - s0_b;
         OP_MUL:  alu_res = s0_a * s0_b;
         OP_ABS:  alu_res = s0_a[DATA_W-1] ? -s0_a : s0_a;
         OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(s0_a) < $signed(s0_b)};
         OP_SLTU: alu_res = {{(DATA_W-1){1'b0}}, s0_a < s0_b};
         OP_SEQ:  alu_res = {{(DATA_W-1){1'b0}}, s0_a == s0_b};
         OP_MIN:  alu_res = ($signed(s0_a) < $signed(s0_b)) ? s0_a : s0_b;
         OP_SLL:  alu_res = s0_a << shamt;
         OP_SRL:  alu_res = s0_a >> shamt;
         OP_SRA:  alu_res = $signed(s0_a) >>> shamt;
         OP_AND:  alu_res = s0_a & s0_b;
         OP_OR:   alu_res = s0_a | s0_b;
         OP_XOR:  alu_res = s0_a ^ s0_b;
         default: begin
            alu_res = '0;
            alu_err = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NP; i++) begin
            p_valid[i] <= 1'b0;
            p_res[i]   <= '0;
            p_err[i]   <= 1'b0;
            p_tag[i]   <= '0;
         end
      end else if (adv) begin
         p_valid[0] <= s0_valid;
         p_res[0]   <= alu_res;
         p_err[0]   <= alu_err;
         p_tag[0]   <= s0_tag;
         for (int i = 1; i < NP; i++) begin
            p_valid[i] <= p_valid[i-1];
            p_res[i]   <= p_res[i-1];
            p_err[i]   <= p_err[i-1];
            p_tag[i]   <= p_tag[i-1];
         end
      end
   end

   // The divider only loads the output register when it is empty, so no overwrite can occur.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
         out_err    <= 1'b0;
      end else if (div_load) begin
         out_valid  <= 1'b1;
         out_result <= div_res;
         out_tag    <= div_tag;
         out_err    <= div_err;
      end else if (adv) begin
         out_valid  <= p_valid[NP-1];
         out_result <= p_res[NP-1];
         out_tag    <= p_tag[NP-1];
         out_err    <= p_err[NP-1];
      end
   end

`ifdef ALU_DIV_EN
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, DRAIN, CALC, DONE} div_state_t;

   div_state_t        div_state;
   logic [DATA_W-1:0] rem_r;
   logic [DATA_W-1:0] quo_r;
   logic [DATA_W-1:0] dvs_r;
   logic [TAG_W-1:0]  dtag_r;
   logic              rem_sel;
   logic [CNT_W-1:0]  cnt;
   logic              pipe_empty;
   logic [DATA_W:0]   shifted;
   logic [DATA_W:0]   trial;
   logic [DATA_W-1:0] rem_nx;
   logic [DATA_W-1:0] quo_nx;
   logic              div_zero_done;
   logic              div_calc_done;

   assign is_div   = (in_op == 4'd14) || (in_op == 4'd15);
   assign div_idle = (div_state == IDLE);

   always_comb begin
      pipe_empty = !s0_valid && !out_valid;
      for (int i = 0; i < NP; i++) begin
         if (p_valid[i]) pipe_empty = 1'b0;
      end
   end

   // quo_r starts as the dividend and shifts quotient bits in from the bottom.
   assign shifted = {rem_r, quo_r[DATA_W-1]};
   assign trial   = shifted - {1'b0, dvs_r};
   assign rem_nx  = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
   assign quo_nx  = {quo_r[DATA_W-2:0], !trial[DATA_W]};

   assign div_zero_done = (div_state == DRAIN) && pipe_empty && (dvs_r == '0);
   assign div_calc_done = (div_state == CALC) && (cnt == CNT_W'(1));
   assign div_load      = div_zero_done || div_calc_done;
   assign div_tag       = dtag_r;
   assign div_err       = div_zero_done;

   always_comb begin
      div_res = '0;
      if (div_zero_done) div_res = rem_sel ? quo_r : '1;
      else               div_res = rem_sel ? rem_nx : quo_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_state <= IDLE;
         rem_r     <= '0;
         quo_r     <= '0;
         dvs_r     <= '0;
         dtag_r    <= '0;
         rem_sel   <= 1'b0;
         cnt       <= '0;
      end else begin
         case (div_state)
            IDLE: begin
               if (acc && is_div) begin
                  quo_r     <= in_a;
                  dvs_r     <= in_b;
                  rem_r     <= '0;
                  rem_sel   <= in_op[0];
                  dtag_r    <= in_tag;
                  div_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (pipe_empty) begin
                  if (dvs_r == '0) begin
                     div_state <= DONE;
                  end else begin
                     cnt       <= CNT_W'(DATA_W);
                     div_state <= CALC;
                  end
               end
            end
            CALC: begin
               rem_r <= rem_nx;
               quo_r <= quo_nx;
               cnt   <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) div_state <= DONE;
            end
            DONE: begin
               if (out_ready) div_state <= IDLE;
            end
            default: div_state <= IDLE;
         endcase
      end
   end
`else
   assign is_div   = 1'b0;
   assign div_idle = 1'b1;
   assign div_load = 1'b0;
   assign div_res  = '0;
   assign div_tag  = '0;
   assign div_err  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Directed bench for alu_pipe_hs: per-op vector table, streaming with back-pressure,
// simultaneous handshakes, reset mid-flight, and divider cases when ALU_DIV_EN is defined.
module tb_alu_pipe_hs;

   localparam int DATA_W     = 32;
   localparam int MUL_STAGES = 1;
   localparam int TAG_W      = 4;
   localparam int LAT        = 2 + MUL_STAGES;
`ifdef ALU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_op;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [TAG_W-1:0]  out_tag;
   logic              out_err;

   int tests = 0;
   int fails = 0;

   alu_pipe_hs #(.DATA_W(DATA_W), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .out_err(out_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   typedef struct {
      logic [3:0]        op;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] res;
      logic              err;
   } vec_t;

   vec_t vt [16];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Offer one op and hold it until accepted; returns at accept edge + 1.
   task automatic send(input logic [3:0] op, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] tag);
      logic ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_tag   = tag;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk) ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      chk("accept", ok, 1'b1);
      in_valid = 1'b0;
   endtask

   // With out_ready high, wait for the next output transfer and compare it.
   task automatic expect_out(input string name, input logic [DATA_W-1:0] res,
                             input logic [TAG_W-1:0] tag, input logic err);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            seen = 1'b1;
            break;
         end
      end
      chk({name, "_valid"}, seen, 1'b1);
      chk({name, "_res"}, out_result, res);
      chk({name, "_tag"}, out_tag, tag);
      chk({name, "_err"}, out_err, err);
   endtask

   initial begin
      int lat;
      int stray;

      vt[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 4'd3,  32'h0000_0000, 1'b0};
      vt[1]  = '{4'd1,  32'h0000_0005, 32'h0000_0007, 4'd1,  32'hFFFF_FFFE, 1'b0};
      vt[2]  = '{4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2,  32'h0000_0001, 1'b0};
      vt[3]  = '{4'd2,  32'h0001_0000, 32'h0001_0001, 4'd4,  32'h0001_0000, 1'b0};
      vt[4]  = '{4'd3,  32'hFFFF_FFF6, 32'h0000_0000, 4'd5,  32'h0000_000A, 1'b0};
      vt[5]  = '{4'd3,  32'h8000_0000, 32'h0000_0000, 4'd6,  32'h8000_0000, 1'b0};
      vt[6]  = '{4'd4,  32'hFFFF_FFFF, 32'h0000_0001, 4'd7,  32'h0000_0001, 1'b0};
      vt[7]  = '{4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 4'd8,  32'h0000_0000, 1'b0};
      vt[8]  = '{4'd6,  32'h0000_0005, 32'h0000_0005, 4'd9,  32'h0000_0001, 1'b0};
      vt[9]  = '{4'd7,  32'hFFFF_FFFE, 32'h0000_0001, 4'd10, 32'hFFFF_FFFE, 1'b0};
      vt[10] = '{4'd8,  32'h0000_0001, 32'h0000_0021, 4'd11, 32'h0000_0002, 1'b0};
      vt[11] = '{4'd9,  32'h8000_0000, 32'h0000_001F, 4'd12, 32'h0000_0001, 1'b0};
      vt[12] = '{4'd10, 32'h8000_0000, 32'h0000_0004, 4'd13, 32'hF800_0000, 1'b0};
      vt[13] = '{4'd11, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd14, 32'h00F0_00F0, 1'b0};
      vt[14] = '{4'd13, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 4'd15, 32'h5555_5555, 1'b0};
`ifdef ALU_DIV_EN
      vt[15] = '{4'd14, 32'h0000_0008, 32'h0000_0002, 4'd0,  32'h0000_0004, 1'b0};
`else
      vt[15] = '{4'd14, 32'h0000_0008, 32'h0000_0002, 4'd0,  32'h0000_0000, 1'b1};
`endif

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_result", out_result, 32'h0);
      chk("rst_out_tag", out_tag, 4'h0);
      chk("rst_out_err", out_err, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);

      // Single ops: exact latency and values.
      for (int i = 0; i < 16; i++) begin
         send(vt[i].op, vt[i].a, vt[i].b, vt[i].tag);
         lat = 0;
         for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
               lat = k;
               break;
            end
         end
         if (!DIV_EN || vt[i].op < 4'd14) chk($sformatf("vec%0d_lat", i), lat, LAT);
         chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
         chk($sformatf("vec%0d_res", i), out_result, vt[i].res);
         chk($sformatf("vec%0d_tag", i), out_tag, vt[i].tag);
         chk($sformatf("vec%0d_err", i), out_err, vt[i].err);
         @(posedge clk);
         #1;
      end

      // Back-to-back stream with out_ready low for three cycles.
      fork
         begin
            send(4'd1,  32'h0000_0005, 32'h0000_0007, 4'd1);
            send(4'd10, 32'h8000_0000, 32'h0000_0004, 4'd2);
            send(4'd7,  32'hFFFF_FFFE, 32'h0000_0001, 4'd3);
         end
         begin
            logic [DATA_W-1:0] sx [3];
            logic [TAG_W-1:0]  stx [3];
            logic              held;
            logic [DATA_W-1:0] held_res;
            logic [TAG_W-1:0]  held_tag;
            int                got;
            int                stalls;
            sx[0] = 32'hFFFF_FFFE; sx[1] = 32'hF800_0000; sx[2] = 32'hFFFF_FFFE;
            stx[0] = 4'd1; stx[1] = 4'd2; stx[2] = 4'd3;
            held = 1'b0; held_res = '0; held_tag = '0; got = 0; stalls = 0;
            for (int c = 0; c < 20 && got < 3; c++) begin
               @(posedge clk);
               #1 out_ready = !(c >= 2 && c <= 4);
               @(negedge clk);
               if (held) begin
                  chk("hold_valid", out_valid, 1'b1);
                  chk("hold_res", out_result, held_res);
                  chk("hold_tag", out_tag, held_tag);
               end
               if (out_valid && !out_ready) begin
                  chk("stall_in_ready", in_ready, 1'b0);
                  stalls++;
               end
               if (out_valid && out_ready) begin
                  chk($sformatf("stream%0d_res", got), out_result, sx[got]);
                  chk($sformatf("stream%0d_tag", got), out_tag, stx[got]);
                  got++;
               end
               held     = out_valid && !out_ready;
               held_res = out_result;
               held_tag = out_tag;
            end
            chk("stream_count", got, 3);
            chk("stream_stalled", stalls > 0, 1'b1);
         end
      join
      @(posedge clk);
      #1 out_ready = 1'b1;

      // Stalled output blocks a new op; releasing both sides at one edge moves both.
      out_ready = 1'b0;
      send(4'd0, 32'd10, 32'd20, 4'd5);
      stray = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) begin
            stray = 1;
            break;
         end
      end
      chk("sim_first_valid", stray, 1);
      chk("sim_first_res", out_result, 32'd30);
      in_valid = 1'b1;
      in_op    = 4'd13;
      in_a     = 32'd3;
      in_b     = 32'd1;
      in_tag   = 4'd6;
      chk("sim_blocked0", in_ready, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("sim_blocked1", in_ready, 1'b0);
      chk("sim_held_res", out_result, 32'd30);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      chk("sim_ready", in_ready, 1'b1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("sim_no_dup", out_valid, 1'b0);
      expect_out("sim_second", 32'd2, 4'd6, 1'b0);

`ifdef ALU_DIV_EN
      fork
         begin
            send(4'd0, 32'd1, 32'd1, 4'd1);
            send(4'd14, 32'd100, 32'd7, 4'd2);
            @(negedge clk);
            chk("divu_busy", in_ready, 1'b0);
            send(4'd15, 32'd100, 32'd7, 4'd3);
            @(negedge clk);
            chk("remu_busy", in_ready, 1'b0);
         end
         begin
            expect_out("seq_add", 32'd2, 4'd1, 1'b0);
            expect_out("seq_divu", 32'd14, 4'd2, 1'b0);
            expect_out("seq_remu", 32'd2, 4'd3, 1'b0);
         end
      join
      send(4'd14, 32'd9, 32'd0, 4'd7);
      expect_out("divu_zero", 32'hFFFF_FFFF, 4'd7, 1'b1);
      send(4'd15, 32'd9, 32'd0, 4'd8);
      expect_out("remu_zero", 32'd9, 4'd8, 1'b1);
      send(4'd14, 32'd100, 32'd7, 4'd9);
      repeat (4) @(posedge clk);
`else
      send(4'd0, 32'd7, 32'd8, 4'd9);
`endif
      // Reset with work in flight: nothing must emerge for it.
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("rstmid_out_valid", out_valid, 1'b0);
      chk("rstmid_out_result", out_result, 32'h0);
      chk("rstmid_in_ready", in_ready, 1'b1);
      stray = 0;
      for (int k = 0; k < DATA_W + LAT + 8; k++) begin
         @(negedge clk);
         if (out_valid) stray++;
      end
      chk("rstmid_no_output", stray, 0);
      @(posedge clk);
      #1;
      send(4'd0, 32'd2, 32'd2, 4'd4);
      expect_out("post_rst_add", 32'd4, 4'd4, 1'b0);

      @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
